// File: rtl/hex_line_formatter_pkg.sv
// ---------------------------------------------------------------------------
// trng_fmt_pkg
// Shared constants, state encoding and nibble-to-ASCII helper for the
// hex line formatter.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package trng_fmt_pkg;

  localparam logic [7:0] ASCII_SPACE       = 8'h20;
  localparam logic [7:0] ASCII_CR          = 8'h0D;
  localparam logic [7:0] ASCII_LF          = 8'h0A;
  localparam logic [7:0] ASCII_DIGIT_BASE  = 8'h30;
  localparam logic [7:0] ASCII_LETTER_BASE = 8'h41;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HI   = 3'd1;
  localparam logic [2:0] ST_LO   = 3'd2;
  localparam logic [2:0] ST_SEP  = 3'd3;
  localparam logic [2:0] ST_CR   = 3'd4;
  localparam logic [2:0] ST_LF   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_HI   = ST_HI,
    S_LO   = ST_LO,
    S_SEP  = ST_SEP,
    S_CR   = ST_CR,
    S_LF   = ST_LF
  } fmt_state_e;

  // Uppercase ASCII hex digit for a 4-bit value.
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
    if (n <= 4'd9) return ASCII_DIGIT_BASE + {4'd0, n};
    else           return ASCII_LETTER_BASE + {4'd0, n} - 8'd10;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hex_line_formatter_if.sv
// ---------------------------------------------------------------------------
// hex_line_formatter_if
// Byte-source and character-sink handshake bundle for the hex formatter.
// master = surrounding system (source + tx), slave = formatter.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface hex_line_formatter_if;
  logic       i_enable;
  logic [7:0] i_dat;
  logic       i_valid;
  logic       o_read;
  logic [7:0] o_char;
  logic       o_write;
  logic       i_ready;
  logic       o_busy;

  modport master (
    output i_enable, i_dat, i_valid, i_ready,
    input  o_read, o_char, o_write, o_busy
  );

  modport slave (
    input  i_enable, i_dat, i_valid, i_ready,
    output o_read, o_char, o_write, o_busy
  );
endinterface

`default_nettype wire

// File: rtl/hex_line_formatter.sv
// ---------------------------------------------------------------------------
// hex_line_formatter
// Turns raw bytes into two uppercase hex characters, an optional space and a
// CR/LF (or LF) line break every BYTES_PER_LINE bytes, one character per
// o_write & i_ready transfer.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hex_line_formatter
  import trng_fmt_pkg::*;
#(
  parameter int BYTES_PER_LINE = 16,
  parameter bit SEP_EN         = 1'b1,
  parameter bit EOL_CR         = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  hex_line_formatter_if.slave  bus
);

  // A single byte per line still needs a one-bit counter.
  localparam int CNT_W = (BYTES_PER_LINE > 1) ? $clog2(BYTES_PER_LINE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES_PER_LINE - 1);

  fmt_state_e       state;
  logic [3:0]       lo_nib;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       char_q;
  logic             write_q;
  logic             rd;
  logic             xfer;

  // Accept only from IDLE; reset overrides a pending byte.
  assign rd   = (state == S_IDLE) & bus.i_enable & bus.i_valid & ~i_reset;
  assign xfer = write_q & bus.i_ready;

  assign bus.o_read  = rd;
  assign bus.o_char  = char_q;
  assign bus.o_write = write_q;
  assign bus.o_busy  = (state != S_IDLE);

  // Formatter FSM: the character for each state is loaded on entry so o_char
  // is already stable for the whole time o_write is high.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= S_IDLE;
      lo_nib  <= 4'h0;
      cnt     <= '0;
      char_q  <= 8'h00;
      write_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rd) begin
            lo_nib  <= bus.i_dat[3:0];
            char_q  <= nibble_to_ascii(bus.i_dat[7:4]);
            write_q <= 1'b1;
            state   <= S_HI;
          end
        end
        S_HI: begin
          if (xfer) begin
            char_q <= nibble_to_ascii(lo_nib);
            state  <= S_LO;
          end
        end
        S_LO: begin
          if (xfer) begin
            if (cnt == CNT_LAST) begin
              cnt <= '0;
              if (EOL_CR) begin
                char_q <= ASCII_CR;
                state  <= S_CR;
              end else begin
                char_q <= ASCII_LF;
                state  <= S_LF;
              end
            end else begin
              cnt <= cnt + 1'b1;
              if (SEP_EN) begin
                char_q <= ASCII_SPACE;
                state  <= S_SEP;
              end else begin
                write_q <= 1'b0;
                state   <= S_IDLE;
              end
            end
          end
        end
        S_CR: begin
          if (xfer) begin
            char_q <= ASCII_LF;
            state  <= S_LF;
          end
        end
        S_SEP, S_LF: begin
          if (xfer) begin
            write_q <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: begin
          write_q <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hex_line_formatter.sv
// ---------------------------------------------------------------------------
// tb_hex_line_formatter
// Three formatter lanes with different parameter sets. Stimulus pushes
// expected characters and directed observations into queues; one monitor
// process pops and compares them.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_hex_line_formatter;

  logic       clk;
  logic       rst   [3];
  logic       en    [3];
  logic       valid [3];
  logic [7:0] dat   [3];
  logic       rdy   [3];
  logic       rd    [3];
  logic       wr    [3];
  logic [7:0] ch    [3];
  logic       busy  [3];

  int rd_cnt [3] = '{0, 0, 0};

  logic [7:0]  exp_q [3][$];
  string       chk_nm [$];
  logic [31:0] chk_act [$];
  logic [31:0] chk_exp [$];

  int checks = 0;
  int errors = 0;

  // Lane 0: 16/1/1, lane 1: 2/1/1, lane 2: 1/0/0
  for (genvar g = 0; g < 3; g++) begin : g_lane
    hex_line_formatter_if bus ();

    hex_line_formatter #(
      .BYTES_PER_LINE((g == 0) ? 16 : ((g == 1) ? 2 : 1)),
      .SEP_EN        (g != 2),
      .EOL_CR        (g != 2)
    ) dut (
      .i_clk  (clk),
      .i_reset(rst[g]),
      .bus    (bus)
    );

    assign bus.i_enable = en[g];
    assign bus.i_valid  = valid[g];
    assign bus.i_dat    = dat[g];
    assign bus.i_ready  = rdy[g];
    assign rd[g]        = bus.o_read;
    assign wr[g]        = bus.o_write;
    assign ch[g]        = bus.o_char;
    assign busy[g]      = bus.o_busy;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count cycles in which each lane consumed a byte.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++)
      if (rd[i]) rd_cnt[i] <= rd_cnt[i] + 1;
  end

  // Monitor: score every character transfer, then drain directed checks.
  always @(negedge clk) begin : mon
    logic [7:0] e;
    for (int i = 0; i < 3; i++) begin
      if (wr[i] && rdy[i]) begin
        checks++;
        if (exp_q[i].size() == 0) begin
          errors++;
          $display("FAIL char lane%0d: got 8'h%h, expected no character", i, ch[i]);
        end else begin
          e = exp_q[i].pop_front();
          if (ch[i] !== e) begin
            errors++;
            $display("FAIL char lane%0d: got 8'h%h, expected 8'h%h", i, ch[i], e);
          end
        end
      end
    end
    while (chk_nm.size() > 0) begin
      string       n;
      logic [31:0] a;
      logic [31:0] x;
      n = chk_nm.pop_front();
      a = chk_act.pop_front();
      x = chk_exp.pop_front();
      checks++;
      if (a !== x) begin
        errors++;
        $display("FAIL %s: got %0h, expected %0h", n, a, x);
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    chk_nm.push_back(n);
    chk_act.push_back(a);
    chk_exp.push_back(x);
  endtask

  task automatic exp3(input int ln, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] c);
    exp_q[ln].push_back(a);
    exp_q[ln].push_back(b);
    exp_q[ln].push_back(c);
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    string s;
    s = "0123456789ABCDEF";
    return s[n];
  endfunction

  // Present a byte and wait (bounded) for it to be consumed; returns at
  // one time unit after the accepting edge.
  task automatic send(input int ln, input logic [7:0] d);
    int n;
    valid[ln] = 1'b1;
    dat[ln]   = d;
    #1;
    n = 0;
    while (!rd[ln] && n < 300) begin
      @(posedge clk); #2;
      n++;
    end
    if (!rd[ln]) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    valid[ln] = 1'b0;
  endtask

  task automatic wait_idle(input int ln);
    int n;
    n = 0;
    while ((exp_q[ln].size() != 0 || busy[ln]) && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 1000) chk("idle_timeout", 0, 1);
  endtask

  initial begin : stim
    int rc;
    logic [7:0] v1 [10] = '{8'h30, 8'h30, 8'h20, 8'h46, 8'h46,
                            8'h0D, 8'h0A, 8'h33, 8'h43, 8'h20};
    logic [7:0] v2 [6]  = '{8'h31, 8'h32, 8'h0A, 8'h39, 8'h42, 8'h0A};

    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; en[i] = 1'b1; valid[i] = 1'b0; dat[i] = 8'h00; rdy[i] = 1'b1;
    end
    valid[0] = 1'b1;
    dat[0]   = 8'hA5;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("reset_write", {31'd0, wr[i]}, 0);
      chk("reset_char", {24'd0, ch[i]}, 0);
      chk("reset_busy", {31'd0, busy[i]}, 0);
      chk("reset_read", {31'd0, rd[i]}, 0);
    end
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    valid[0] = 1'b0;
    @(posedge clk); #1;

    // Single byte 0xA5 with tx always ready.
    rc = rd_cnt[0];
    exp3(0, 8'h41, 8'h35, 8'h20);
    send(0, 8'hA5);
    chk("latency_write", {31'd0, wr[0]}, 1);
    chk("latency_char", {24'd0, ch[0]}, 32'h41);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("busy_in_sep", {31'd0, busy[0]}, 1);
    @(posedge clk); #1;
    chk("busy_after_sep", {31'd0, busy[0]}, 0);
    chk("read_pulse_len", rd_cnt[0] - rc, 1);

    // Stall in LO of 0x7E for 100 cycles with another byte waiting.
    exp3(0, 8'h37, 8'h45, 8'h20);
    send(0, 8'h7E);
    @(posedge clk); #1;
    rdy[0] = 1'b0;
    valid[0] = 1'b1;
    dat[0] = 8'h3C;
    rc = rd_cnt[0];
    begin
      int ok;
      ok = 1;
      repeat (100) begin
        @(posedge clk); #1;
        if (ch[0] !== 8'h45 || wr[0] !== 1'b1) ok = 0;
      end
      chk("stall_hold", ok, 1);
    end
    chk("stall_no_read", rd_cnt[0] - rc, 0);
    exp3(0, 8'h33, 8'h43, 8'h20);
    rdy[0] = 1'b1;
    send(0, 8'h3C);
    wait_idle(0);

    // Disabled source: nothing consumed, nothing emitted.
    en[0] = 1'b0;
    valid[0] = 1'b1;
    dat[0] = 8'h11;
    rc = rd_cnt[0];
    repeat (20) @(posedge clk);
    #1;
    chk("disabled_no_read", rd_cnt[0] - rc, 0);
    chk("disabled_no_write", {31'd0, wr[0]}, 0);
    en[0] = 1'b1;
    exp3(0, 8'h31, 8'h31, 8'h20);
    send(0, 8'h11);
    wait_idle(0);

    // Drop enable during HI: byte completes, then block waits in IDLE.
    exp3(0, 8'h32, 8'h32, 8'h20);
    send(0, 8'h22);
    rc = rd_cnt[0];
    en[0] = 1'b0;
    valid[0] = 1'b1;
    dat[0] = 8'h33;
    repeat (20) @(posedge clk);
    #1;
    chk("disable_mid_no_read", rd_cnt[0] - rc, 0);
    chk("disable_mid_idle", {31'd0, busy[0]}, 0);
    en[0] = 1'b1;
    exp3(0, 8'h33, 8'h33, 8'h20);
    send(0, 8'h33);
    wait_idle(0);

    // Reset in HI of the 3rd byte of a fresh line.
    rst[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    exp3(0, 8'h30, 8'h31, 8'h20);
    exp3(0, 8'h30, 8'h32, 8'h20);
    send(0, 8'h01);
    send(0, 8'h02);
    exp_q[0].push_back(8'h30);
    send(0, 8'h03);
    rst[0] = 1'b1;
    valid[0] = 1'b1;
    dat[0] = 8'h55;
    rc = rd_cnt[0];
    @(posedge clk); #1;
    chk("midreset_write", {31'd0, wr[0]}, 0);
    chk("midreset_busy", {31'd0, busy[0]}, 0);
    chk("midreset_char", {24'd0, ch[0]}, 0);
    chk("reset_beats_valid", {31'd0, rd[0]}, 0);
    @(posedge clk); #1;
    chk("reset_no_consume", rd_cnt[0] - rc, 0);
    rst[0] = 1'b0;
    valid[0] = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      logic [7:0] kb;
      kb = 8'(k);
      exp_q[0].push_back(hexc(kb[7:4]));
      exp_q[0].push_back(hexc(kb[3:0]));
      if (k < 16) exp_q[0].push_back(8'h20);
      else begin
        exp_q[0].push_back(8'h0D);
        exp_q[0].push_back(8'h0A);
      end
    end
    for (int k = 1; k <= 16; k++) send(0, 8'(k));
    wait_idle(0);

    // Two bytes per line.
    foreach (v1[i]) exp_q[1].push_back(v1[i]);
    send(1, 8'h00);
    chk("lane1_first_char", {24'd0, ch[1]}, 32'h30);
    send(1, 8'hFF);
    send(1, 8'h3C);
    wait_idle(1);

    // One byte per line, no separator, LF-only line end.
    foreach (v2[i]) exp_q[2].push_back(v2[i]);
    send(2, 8'h12);
    send(2, 8'h9B);
    wait_idle(2);

    for (int i = 0; i < 3; i++) chk("leftover_chars", exp_q[i].size(), 0);
    repeat (3) @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
